// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer for a shared single-port synchronous memory.
// Define MEM_ARB_RR_EN for round-robin on contention; otherwise port 0 has fixed priority.
module mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p0_ack,
  output logic              p1_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } acc_t;

  state_t            state_q, state_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_din_q, mem_din_d;
  logic              win_q, win_d;
  logic              last_grant_q, last_grant_d;
  logic              win_c;
  acc_t [1:0]        acc;

  assign acc[0] = '{we: p0_we, addr: p0_addr, data: p0_wdata};
  assign acc[1] = '{we: p1_we, addr: p1_addr, data: p1_wdata};

  // Winner index; only meaningful when at least one port requests.
  always_comb begin
`ifdef MEM_ARB_RR_EN
    if (p0_req && p1_req) win_c = ~last_grant_q;
    else                  win_c = !p0_req;
`else
    win_c = !p0_req;
`endif
  end

  always_comb begin
    state_d      = state_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_din_d    = mem_din_q;
    win_d        = win_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (p0_req || p1_req) begin
          mem_we_d     = acc[win_c].we;
          mem_addr_d   = acc[win_c].addr;
          mem_din_d    = acc[win_c].data;
          win_d        = win_c;
          last_grant_d = win_c;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        mem_we_d = 1'b0;
        state_d  = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // last_grant resets to 1 so port 0 wins the first contended grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
      win_q        <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_din_q    <= mem_din_d;
      win_q        <= win_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign busy     = (state_q != IDLE);
  assign p0_ack   = (state_q == RESP) && !win_q;
  assign p1_ack   = (state_q == RESP) &&  win_q;
  assign rdata    = mem_dout;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural write-first memory plus an ack scoreboard.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       p0_req, p0_we, p1_req, p1_we;
  logic [7:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic       p0_ack, p1_ack, busy, mem_we;
  logic [7:0] rdata, mem_addr, mem_din, mem_dout;

  int checks = 0;
  int failures = 0;
  int we_cyc = 0;

  typedef struct { logic port; logic [7:0] data; } exp_t;
  exp_t sb[$];

  logic [7:0] mem [256];

  mem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p0_ack(p0_ack), .p1_ack(p1_ack), .rdata(rdata), .busy(busy),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[5] = 8'h5A;
    mem[6] = 8'h66;
  end

  // Write-first synchronous memory.
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_din;
      mem_dout      <= mem_din;
    end else begin
      mem_dout <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mem_we) we_cyc++;
    if (rst_n && (p0_ack || p1_ack)) begin
      chk("ack_excl", {31'd0, p0_ack & p1_ack}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_ack", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ack_port", {31'd0, p1_ack}, {31'd0, e.port});
        chk("rdata", {24'd0, rdata}, {24'd0, e.data});
      end
    end
  end

  task automatic drive(input logic port, input logic we, input logic [7:0] a, input logic [7:0] d);
    if (!port) begin p0_req = 1'b1; p0_we = we; p0_addr = a; p0_wdata = d; end
    else       begin p1_req = 1'b1; p1_we = we; p1_addr = a; p1_wdata = d; end
  endtask

  // Single access: request, wait (bounded) for this port's ack, release.
  task automatic access(input logic port, input logic we, input logic [7:0] a,
                        input logic [7:0] d, input logic [7:0] exp);
    int n;
    bit got;
    @(negedge clk);
    drive(port, we, a, d);
    sb.push_back('{port: port, data: exp});
    got = 0;
    for (n = 1; n <= 8 && !got; n++) begin
      @(negedge clk);
      if ((port ? p1_ack : p0_ack)) got = 1;
    end
    chk("ack_seen", {31'd0, got}, 32'd1);
    if (port) p1_req = 1'b0; else p0_req = 1'b0;
  endtask

  initial begin
    int last, cyc, n;
    bit got;
    logic exp_port;
    rst_n = 1'b0;
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
    repeat (2) @(negedge clk);
    chk("rst_outs", {27'd0, busy, mem_we, p0_ack, p1_ack, 1'b0}, 32'd0);
    chk("rst_addr_din", {16'd0, mem_addr, mem_din}, 32'd0);
    rst_n = 1'b1;

    // p0 write 0x10 <= A5 with explicit cycle timing.
    @(negedge clk);
    we_cyc = 0;
    drive(1'b0, 1'b1, 8'h10, 8'hA5);
    sb.push_back('{port: 1'b0, data: 8'hA5});
    @(negedge clk);
    chk("issue_we", {31'd0, mem_we}, 32'd1);
    chk("issue_addr", {24'd0, mem_addr}, 32'h10);
    chk("issue_din", {24'd0, mem_din}, 32'hA5);
    chk("issue_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("resp_p0ack", {31'd0, p0_ack}, 32'd1);
    chk("resp_we", {31'd0, mem_we}, 32'd0);
    p0_req = 1'b0;
    @(negedge clk);
    chk("we_one_cycle", we_cyc, 1);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // p1 reads back the written data.
    access(1'b1, 1'b0, 8'h10, 8'h00, 8'hA5);
    access(1'b1, 1'b1, 8'h30, 8'h77, 8'h77);

    // Contention: both ports hold reads; four acks at 3-cycle spacing.
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h10, 8'h00);
    drive(1'b1, 1'b0, 8'h30, 8'h00);
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
      exp_port = k[0];
`else
      exp_port = 1'b0;
`endif
      sb.push_back('{port: exp_port, data: exp_port ? 8'h77 : 8'hA5});
    end
    cyc = 0; last = 0;
    for (int k = 0; k < 4; k++) begin
      got = 0;
      for (n = 0; n < 8 && !got; n++) begin
        @(negedge clk);
        cyc++;
        if (p0_ack || p1_ack) got = 1;
      end
      chk("cont_ack_seen", {31'd0, got}, 32'd1);
      chk("cont_spacing", cyc - last, (k == 0) ? 2 : 3);
      last = cyc;
    end
    p0_req = 1'b0; p1_req = 1'b0;
    @(negedge clk);
    chk("cont_sb_empty", sb.size(), 0);

    // Idle for 10 cycles.
    we_cyc = 0;
    got = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (busy || mem_we || p0_ack || p1_ack) got = 1;
    end
    chk("idle_quiet", {31'd0, got}, 32'd0);

    // Reset during ISSUE of a write aborts it.
    @(negedge clk);
    drive(1'b0, 1'b1, 8'h20, 8'h3C);
    @(negedge clk);
    chk("abort_issue_we", {31'd0, mem_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_we_drop", {30'd0, mem_we, busy}, 32'd0);
    chk("abort_no_ack", {30'd0, p0_ack, p1_ack}, 32'd0);
    p0_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_sb_empty", sb.size(), 0);
    access(1'b1, 1'b0, 8'h20, 8'h00, 8'h00);

    // Address change during ISSUE has no effect.
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h05, 8'h00);
    sb.push_back('{port: 1'b0, data: 8'h5A});
    @(negedge clk);
    p0_addr = 8'h06;
    #1;
    chk("hold_addr", {24'd0, mem_addr}, 32'h05);
    got = 0;
    for (n = 0; n < 8 && !got; n++) begin
      @(negedge clk);
      if (p0_ack) got = 1;
    end
    chk("hold_ack_seen", {31'd0, got}, 32'd1);
    p0_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("final_sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer for the shared single-port 256x8 synchronous memory. It sits between the memory and two requesters: port 0 is the CPU load/store/fetch path, port 1 is the loader/debug path. It serializes their accesses, drives the memory's write enable, address and write data, and returns the memory's synchronous read data with a one-cycle acknowledge. Round-robin fairness is a compile-time option; without it, port 0 has fixed priority.

## Interface
- ADDR_W, 8, address width; matches memory depth of 2**ADDR_W.
- DATA_W, 8, data width.
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- p0_req, p1_req  in  1  access request; held high with fields stable until ack.
- p0_we, p1_we  in  1  1 = write, 0 = read.
- p0_addr, p1_addr  in  ADDR_W  access address.
- p0_wdata, p1_wdata  in  DATA_W  write data; ignored on reads.
- p0_ack, p1_ack  out  1  one-cycle pulse: access complete, rdata valid.
- rdata  out  DATA_W  read data; shared by both ports, valid only while an ack is high.
- busy  out  1  high in ISSUE and RESP.
- mem_we  out  1  to memory we.
- mem_addr  out  ADDR_W  to memory addr.
- mem_din  out  DATA_W  to memory d_i.
- mem_dout  in  DATA_W  from memory d_o (registered in memory, one-cycle latency).

## Operation
- FSM states: IDLE, ISSUE, RESP. Reset state IDLE.
- IDLE: if no req, stay. If any req, pick winner, register mem_addr, mem_din and mem_we from the winner's fields, latch winner index, go to ISSUE.
- ISSUE: memory outputs stable; memory samples on the edge ending this cycle. mem_we cleared on that edge. Go to RESP.
- RESP: mem_dout holds the memory's result. rdata = mem_dout (combinational passthrough); ack of latched winner high, the other low. Go to IDLE.
- Writes: memory is write-first, so a write's ack returns the written data on rdata.
- Arbitration with both ports requesting: round-robin (see Configuration) or port 0 wins. A single requester always wins.
- last_grant register updated on every IDLE->ISSUE transition to the winner index.
- Requester rules: req and fields held stable from assertion until the ack cycle inclusive. To issue back-to-back, keep req high with new fields in the cycle after ack; the arbiter re-samples in IDLE. Dropping req before ack is a protocol violation; the arbiter completes the latched access anyway and still pulses ack.
- Request fields are sampled only in IDLE; changes during ISSUE/RESP have no effect.

## Timing
- Reset values: state IDLE, mem_we 0, mem_addr 0, mem_din 0, p0_ack 0, p1_ack 0, busy 0, last_grant 1 (so port 0 wins the first contended grant). rdata follows mem_dout.
- Latency: req sampled high at edge E0 -> ISSUE in cycle after E0 -> ack high in cycle after E1 -> cycle after E2 is IDLE.
- Throughput: one access per 3 cycles; back-to-back requests reach ack every 3 cycles.
- mem_we is high for exactly one cycle (ISSUE) per write; never high outside ISSUE.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronous); mem_we drops, so no write occurs on the next edge; no ack is issued for the aborted access. After release, requesters still holding req are re-arbitrated from IDLE.
- Simultaneous requests arriving in the same cycle are treated as contention; there is no queuing beyond the held req lines.

## Configuration
- MEM_ARB_RR_EN defined: round-robin. On contention, the grant goes to the port not equal to last_grant; consecutive contended grants alternate 0,1,0,1...
- MEM_ARB_RR_EN undefined: fixed priority; port 0 always wins contention. last_grant is still updated but not used for the decision.

## Test plan
- Reset, then p0 write addr 0x10 data 0xA5 -> mem_we high exactly one cycle with mem_addr 0x10, mem_din 0xA5; p0_ack pulses with rdata 0xA5 two cycles after request.
- p1 read addr 0x10 after that write -> p1_ack pulses with rdata 0xA5, p0_ack stays 0.
- Both ports hold read requests for 4 accesses, with MEM_ARB_RR_EN defined -> grant order 0,1,0,1 with acks every 3 cycles; undefined -> four p0 acks, p1 stalls.
- Idle ports for 10 cycles -> busy 0, mem_we 0, no acks.
- p0 write addr 0x20 data 0x3C, assert rst_n low during ISSUE -> mem_we drops immediately, no ack; a subsequent read of 0x20 does not return 0x3C (location preloaded with 0x00).
- p0 changes addr during ISSUE from 0x05 to 0x06 -> access completes on 0x05; rdata equals the contents of 0x05.
